// File: rtl/puf_pkg.sv
// Shared types and sizes for the PUF response collector.
package puf_pkg;

  localparam int unsigned ARB_W         = 8;
  localparam int unsigned CHAL_PER_WORD = 4;
  localparam int unsigned RESP_W        = 32;

  typedef enum logic [2:0] {
    StIdle,
    StRace,
    StSample,
    StRearm,
    StCommit,
    StDone
  } puf_state_e;

endpackage

// File: rtl/puf_response_collector_if.sv
// Host-side request/response handshake of the PUF response collector.
interface puf_response_collector_if;
  import puf_pkg::*;

  logic              start;
  logic [ARB_W-1:0]  challenge_base;
  logic [RESP_W-1:0] resp_data;
  logic              resp_valid;
  logic              resp_ready;
  logic              busy;
  logic              unstable;

  modport master (
    output start, challenge_base, resp_ready,
    input  resp_data, resp_valid, busy, unstable
  );

  modport slave (
    input  start, challenge_base, resp_ready,
    output resp_data, resp_valid, busy, unstable
  );

endinterface

// File: rtl/puf_vote_counter.sv
// Per-arbiter-bit vote counters with majority and unanimity outputs.
module puf_vote_counter
  import puf_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             accumulate,
  input  logic [ARB_W-1:0] sample_bits,
  output logic [ARB_W-1:0] majority,
  output logic             unanimous
);

  localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1);

  logic [CNT_W-1:0] cnt_q [ARB_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ARB_W; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < ARB_W; i++) begin
        if (clear) begin
          cnt_q[i] <= '0;
        end else if (accumulate && sample_bits[i] && (cnt_q[i] != CNT_W'(NUM_SAMPLES))) begin
          // Saturating guard: the FSM never issues more than NUM_SAMPLES accumulates.
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    majority  = '0;
    unanimous = 1'b1;
    for (int i = 0; i < ARB_W; i++) begin
      majority[i] = cnt_q[i] > CNT_W'(NUM_SAMPLES / 2);
      if ((cnt_q[i] != '0) && (cnt_q[i] != CNT_W'(NUM_SAMPLES))) unanimous = 1'b0;
    end
  end

endmodule

// File: rtl/puf_response_collector.sv
// Races the PUF array over four consecutive challenges and packs a 32-bit response.
// Majority voting over NUM_SAMPLES races is enabled by PUF_MAJORITY_VOTE_EN.
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_SAMPLES   = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  puf_response_collector_if.slave host,
  input  logic [ARB_W-1:0]        arb_in,
  output logic [RESP_W-1:0]       puf_enable,
  output logic [ARB_W-1:0]        puf_challenge
);

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int unsigned EFF_SAMPLES = NUM_SAMPLES;
`else
  // Single race per challenge; NUM_SAMPLES only matters with voting enabled.
  localparam int unsigned EFF_SAMPLES = NUM_SAMPLES / NUM_SAMPLES;
`endif
  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SMP_W  = $clog2(EFF_SAMPLES + 1);
  localparam int unsigned LANE_W = $clog2(CHAL_PER_WORD);

  puf_state_e        state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [SMP_W-1:0]  smp_q, smp_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ARB_W-1:0]  chal_q, chal_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic              unstable_q, unstable_d;

`ifdef PUF_MAJORITY_VOTE_EN
  logic             vote_clear, vote_acc, vote_unan;
  logic [ARB_W-1:0] vote_major;

  puf_vote_counter #(
    .NUM_SAMPLES (NUM_SAMPLES)
  ) u_vote (
    .clock       (clock),
    .reset       (reset),
    .clear       (vote_clear),
    .accumulate  (vote_acc),
    .sample_bits (arb_in),
    .majority    (vote_major),
    .unanimous   (vote_unan)
  );
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      settle_q   <= '0;
      smp_q      <= '0;
      lane_q     <= '0;
      chal_q     <= '0;
      resp_q     <= '0;
      unstable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      smp_q      <= smp_d;
      lane_q     <= lane_d;
      chal_q     <= chal_d;
      resp_q     <= resp_d;
      unstable_q <= unstable_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    smp_d      = smp_q;
    lane_d     = lane_q;
    chal_d     = chal_q;
    resp_d     = resp_q;
    unstable_d = unstable_q;
`ifdef PUF_MAJORITY_VOTE_EN
    vote_clear = 1'b0;
    vote_acc   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (host.start) begin
          chal_d     = host.challenge_base;
          resp_d     = '0;
          unstable_d = 1'b0;
          lane_d     = '0;
          smp_d      = '0;
          settle_d   = '0;
`ifdef PUF_MAJORITY_VOTE_EN
          vote_clear = 1'b1;
`endif
          state_d    = StRace;
        end
      end
      StRace: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          state_d  = StSample;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StSample: begin
        smp_d = smp_q + 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
        vote_acc = 1'b1;
`else
        resp_d[lane_q*ARB_W +: ARB_W] = arb_in;
`endif
        state_d = StRearm;
      end
      StRearm: begin
        // Every race, including the last of a challenge, is disarmed before moving on.
        state_d = (smp_q == SMP_W'(EFF_SAMPLES)) ? StCommit : StRace;
      end
      StCommit: begin
`ifdef PUF_MAJORITY_VOTE_EN
        resp_d[lane_q*ARB_W +: ARB_W] = vote_major;
        if (!vote_unan) unstable_d = 1'b1;
        vote_clear = 1'b1;
`endif
        smp_d = '0;
        if (lane_q == LANE_W'(CHAL_PER_WORD - 1)) begin
          state_d = StDone;
        end else begin
          lane_d  = lane_q + 1'b1;
          chal_d  = chal_q + ARB_W'(1);
          state_d = StRace;
        end
      end
      StDone: begin
        if (host.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign puf_enable      = (state_q == StRace) ? '1 : '0;
  assign puf_challenge   = chal_q;
  assign host.resp_data  = resp_q;
  assign host.resp_valid = (state_q == StDone);
  assign host.busy       = (state_q != StIdle);
  assign host.unstable   = unstable_q;

endmodule
